// File: rtl/key_event_pkg.sv
// Shared types and timing constants for the pushbutton event generator.
// Holds the per-key FSM state encoding plus board and simulation timing sets.
package key_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_e;

    localparam int DEF_NKEYS               = 4;
    localparam int DEF_DEBOUNCE_CYCLES     = 500000;
    localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
    localparam int DEF_REPEAT_RATE_CYCLES  = 5000000;

    localparam int SIM_DEBOUNCE_CYCLES     = 4;
    localparam int SIM_REPEAT_DELAY_CYCLES = 10;
    localparam int SIM_REPEAT_RATE_CYCLES  = 3;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// Key bundle between the board keys / consumer logic and the event generator.
// The master side is the generator: it takes raw keys and drives the events.
interface key_event_gen_if #(
    parameter int NKEYS = 4
);
    logic [NKEYS-1:0] key_n;
    logic [NKEYS-1:0] repeat_en;
    logic [NKEYS-1:0] held;
    logic [NKEYS-1:0] press;
    logic [NKEYS-1:0] release_pulse;

    modport master (
        input  key_n,
        input  repeat_en,
        output held,
        output press,
        output release_pulse
    );

    modport slave (
        output key_n,
        output repeat_en,
        input  held,
        input  press,
        input  release_pulse
    );
endinterface

// File: rtl/key_event_chan.sv
// One key channel: 2-flop synchronizer, restartable debounce counter and the
// IDLE/DELAY/REPEAT auto-repeat FSM with registered held/press/release outputs.
module key_event_chan
    import key_event_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n_i,
    input  logic repeat_en_i,
    output logic held_o,
    output logic press_o,
    output logic release_o
);

    localparam int DW   = cnt_width(DEBOUNCE_CYCLES);
    localparam int RMAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                          REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int RW   = cnt_width(RMAX);

    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [DW-1:0] db_cnt_q;
    logic [DW-1:0] db_cnt_d;
    logic [RW-1:0] rep_cnt_q;
    key_state_e    state_q;
    logic          held_q;
    logic          press_q;
    logic          release_q;
    logic          mismatch_s;
    logic          accept_s;

    // Synchronizer idles at 1 so a reset looks like "released".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
        end
    end

    assign mismatch_s = (~sync_q[1]) != held_q;
    assign accept_s   = mismatch_s && (db_cnt_q == DB_LAST);

    // Debounce count restarts on any cycle where the level agrees with held.
    always_comb begin
        db_cnt_d = {DW{1'b0}};
        if (!mismatch_s || accept_s) begin
            db_cnt_d = {DW{1'b0}};
        end else begin
            db_cnt_d = db_cnt_q + DW'(1'b1);
        end
    end

    // Debounce counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= {DW{1'b0}};
        end else begin
            db_cnt_q <= db_cnt_d;
        end
    end

    // Repeat FSM: an accepted release always outranks a repeat expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rep_cnt_q <= {RW{1'b0}};
            held_q    <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    rep_cnt_q <= {RW{1'b0}};
                    if (accept_s) begin
                        state_q <= ST_DELAY;
                        held_q  <= 1'b1;
                        press_q <= 1'b1;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (accept_s) begin
                        state_q   <= ST_IDLE;
                        held_q    <= 1'b0;
                        release_q <= 1'b1;
                        rep_cnt_q <= {RW{1'b0}};
                    end else if (!repeat_en_i) begin
                        state_q   <= ST_DELAY;
                        rep_cnt_q <= {RW{1'b0}};
                    end else if (rep_cnt_q == ((state_q == ST_DELAY) ? DLY_LAST : RATE_LAST)) begin
                        state_q   <= ST_REPEAT;
                        press_q   <= 1'b1;
                        rep_cnt_q <= {RW{1'b0}};
                    end else begin
                        rep_cnt_q <= rep_cnt_q + RW'(1'b1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    rep_cnt_q <= {RW{1'b0}};
                    held_q    <= 1'b0;
                end
            endcase
        end
    end

    assign held_o    = held_q;
    assign press_o   = press_q;
    assign release_o = release_q;

endmodule

// File: rtl/key_event_gen.sv
// Pushbutton event generator: one independent debounce/auto-repeat channel
// per board key, presented to consumers through key_event_gen_if.
module key_event_gen
    import key_event_pkg::*;
#(
    parameter int NKEYS               = DEF_NKEYS,
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
    input logic             clk,
    input logic             rst_n,
    key_event_gen_if.master evt
);

    logic [NKEYS-1:0] held_s;
    logic [NKEYS-1:0] press_s;
    logic [NKEYS-1:0] release_s;

    for (genvar g = 0; g < NKEYS; g++) begin : g_chan
        key_event_chan #(
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
        ) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .key_n_i     (evt.key_n[g]),
            .repeat_en_i (evt.repeat_en[g]),
            .held_o      (held_s[g]),
            .press_o     (press_s[g]),
            .release_o   (release_s[g])
        );
    end

    assign evt.held          = held_s;
    assign evt.press         = press_s;
    assign evt.release_pulse = release_s;

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Producer side of the pushbutton interface consumed by the clock/set-mode logic.
- Turns raw, bouncing, active-low board keys (KEY[3:0]) into clean per-key events:
  - a debounced level;
  - single-cycle press and release pulses;
  - optional auto-repeat press pulses while a key is held.
- Lets consumers drop their own oldKEY edge detection and gain hold-to-scroll for hour/minute setting.

Parameters:
- NKEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be >= 1.
- REPEAT_DELAY_CYCLES, 25000000, cycles from the initial press pulse to the first repeat pulse (500 ms); must be >= 1.
- REPEAT_RATE_CYCLES, 5000000, cycles between successive repeat pulses (100 ms); must be >= 1.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst_n  in  1  asynchronous active-low reset.
- key_n  in  NKEYS  raw asynchronous key inputs, 0 = pressed.
- repeat_en  in  NKEYS  per-key auto-repeat enable, synchronous to clk.
- held  out  NKEYS  debounced level, 1 = pressed.
- press  out  NKEYS  one-cycle pulse on accepted press and on each repeat.
- release  out  NKEYS  one-cycle pulse on accepted release.

Behaviour:
- Reset (async assert, sync use):
  - Synchronizer flops reset to 1 (released).
  - held, press and release = 0; all counters = 0; every FSM in IDLE.
- Per key, the input passes through a 2-flop synchronizer before any other logic.
- Debounce:
  - The counter increments each cycle the synchronized level differs from held.
  - It clears to 0 any cycle they match, so a bounce restarts the count.
  - At count == DEBOUNCE_CYCLES-1 with mismatch still present, the change is accepted next edge.
  - Latency: a clean raw press stable from cycle t gives held=1 and press=1 in cycle t+2+DEBOUNCE_CYCLES. Release latency is identical.
- FSM per key:
  - IDLE: held=0.
    - Accepted press -> DELAY, with press pulse and held=1.
  - DELAY: repeat counter counts.
    - Accepted release -> IDLE, with release pulse.
    - repeat_en=1 and count == REPEAT_DELAY_CYCLES-1 -> REPEAT, with press pulse; counter cleared.
  - REPEAT:
    - Press pulse every REPEAT_RATE_CYCLES cycles.
    - Accepted release -> IDLE, with release pulse.
- repeat_en=0 while in DELAY or REPEAT:
  - Repeat counter held at 0; no repeat pulses.
  - State returns to or stays in DELAY.
  - Re-asserting repeat_en restarts the full REPEAT_DELAY_CYCLES wait.
- Release acceptance coinciding with a repeat-counter expiry: release wins, and no press pulse fires that cycle.
- press and release are never both 1 on the same key in the same cycle.
- Channels are fully independent. Simultaneous events on different keys all appear in the same cycle.
- Key held through reset deassertion: held starts 0, and press fires DEBOUNCE_CYCLES+2 cycles after rst_n rises (no suppression).
- Reset asserted mid-debounce or mid-repeat: immediate return to reset values, with no pulse emitted on deassertion unless the debounce completes again.
- Counter widths: $clog2 of the respective parameter (minimum 1 bit). Counters never wrap, because they clear on match, expiry, or state exit.

Decomposition:
- Package key_event_pkg holds:
  - FSM state enum (IDLE, DELAY, REPEAT);
  - default timing constants for 50 MHz;
  - a simulation timing set (DEBOUNCE=4, DELAY=10, RATE=3).
- One sub-module, key_event_chan: a single key containing synchronizer, debounce counter, repeat FSM and counter.
- key_event_gen instantiates key_event_chan in a generate loop over NKEYS.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3, NKEYS=4):
- Clean press: key_n[0] falls at cycle 0 and stays low -> held[0]=1 and press[0]=1 exactly at cycle 6. Release at cycle 20 -> release[0]=1 at cycle 26, held[0]=0.
- Bounce: key_n[1] toggles low/high/low every 2 cycles for 8 cycles, then stays low -> no press until 6 cycles after the final fall; exactly one press pulse.
- Auto-repeat: repeat_en[2]=1, key held 40 cycles -> press pulses at cycles 6, 16, 19, 22, 25, ...; one release pulse after release.
- Repeat disable mid-hold: repeat_en[2] drops during REPEAT -> no further press pulses. Re-enable -> next pulse 10 cycles later.
- Simultaneous keys: keys 0 and 3 pressed same cycle, repeat_en=0 -> press=4'b1001 in one cycle, with no repeats while held.
- Reset: rst_n low mid-debounce and mid-repeat -> outputs 0 immediately. Key held across reset -> press 6 cycles after rst_n rises.
